// File: rtl/inst_mem_loadable.sv
// inst_mem_loadable: synchronous-read instruction memory that is programmed at
// run time through a chunk-serial load port, then serves one-cycle-latency
// fetches once the load/run state machine reaches RUN.
//
// Ports:
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   LoadStart, LoadEnd           begin/restart and end a program load (pulses)
//   LoadValid, LoadData[LW]      chunk stream, most significant chunk first
//   LoadReady, Loading           chunk acceptance, state == LOAD
//   LoadErr                      sticky: load ended on a partial word
//   WordCount[A+1]               complete words written by the last load
//   FetchReq, InstAddress[A]     fetch request and address
//   InstOut[W], InstValid        fetched instruction and its valid strobe
//   OutOfRange, ParityErr        fetch status, qualified by InstValid
//
// Optional feature: define INSTMEM_PARITY_EN to store an even-parity bit with
// every word and flag mismatches on fetch; otherwise ParityErr stays 0.

module inst_mem_loadable #(
  parameter int unsigned A   = 10,
  parameter int unsigned W   = 9,
  parameter int unsigned LW  = 3,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          LoadStart,
  input  logic          LoadEnd,
  input  logic          LoadValid,
  input  logic [LW-1:0] LoadData,
  output logic          LoadReady,
  output logic          Loading,
  output logic          LoadErr,
  output logic [A:0]    WordCount,
  input  logic          FetchReq,
  input  logic [A-1:0]  InstAddress,
  output logic [W-1:0]  InstOut,
  output logic          InstValid,
  output logic          OutOfRange,
  output logic          ParityErr
);

  localparam int unsigned DEPTH = 2 ** A;
  localparam int unsigned CH    = W / LW;
  localparam int unsigned CW    = (CH > 1) ? $clog2(CH) : 1;
`ifdef INSTMEM_PARITY_EN
  localparam int unsigned MW    = W + 1;
`else
  localparam int unsigned MW    = W;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // The word must split into whole chunks.
  generate
    if ((W % LW) != 0) begin : g_bad_chunk_width
      $error("inst_mem_loadable: W must be a multiple of LW");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [A-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] chunk_cnt_q, chunk_cnt_d;
  logic [W-1:0]  asm_q, asm_d;
  logic [A:0]    word_count_q, word_count_d;
  logic          load_err_q, load_err_d;
  logic          load_ready_q, load_ready_d;
  logic          loading_q, loading_d;
  logic [W-1:0]  inst_out_q, inst_out_d;
  logic          inst_valid_q, inst_valid_d;
  logic          oor_q, oor_d;
  logic          perr_q, perr_d;

  logic          chunk_acc_c;
  logic          mem_we_c;
  logic [MW-1:0] mem_wdata_c;
  logic [MW-1:0] rd_word_c;

  logic [MW-1:0] mem [DEPTH];

  // Program array: written only while loading, never reset.
  always_ff @(posedge Clk) begin
    if (mem_we_c) begin
      mem[wr_ptr_q] <= mem_wdata_c;
    end
  end

  // Next-state, load assembly and fetch response.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    chunk_cnt_d  = chunk_cnt_q;
    asm_d        = asm_q;
    word_count_d = word_count_q;
    load_err_d   = load_err_q;
    inst_out_d   = inst_out_q;
    inst_valid_d = 1'b0;
    oor_d        = 1'b0;
    perr_d       = 1'b0;
    mem_we_c     = 1'b0;
    rd_word_c    = mem[InstAddress];
    chunk_acc_c  = (state_q == ST_LOAD) && LoadValid && load_ready_q && !LoadStart;

    if (LoadStart) begin
      // Restart wins over everything else in the same cycle.
      state_d      = ST_LOAD;
      wr_ptr_d     = '0;
      chunk_cnt_d  = '0;
      word_count_d = '0;
      load_err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (chunk_acc_c) begin
            asm_d = W'({asm_q, LoadData});
            if (chunk_cnt_q == CW'(CH - 1)) begin
              mem_we_c     = 1'b1;
              chunk_cnt_d  = '0;
              wr_ptr_d     = wr_ptr_q + A'(1);
              word_count_d = word_count_q + (A+1)'(1);
              if (wr_ptr_q == A'(DEPTH - 1)) begin
                state_d = ST_RUN;
              end
            end else begin
              chunk_cnt_d = chunk_cnt_q + CW'(1);
            end
          end
          // Partial check uses the count after this cycle's chunk.
          if (LoadEnd) begin
            state_d = ST_RUN;
            if (chunk_cnt_d != '0) begin
              load_err_d  = 1'b1;
              chunk_cnt_d = '0;
            end
          end
        end
        ST_RUN: begin
          if (FetchReq) begin
            inst_valid_d = 1'b1;
            if ({1'b0, InstAddress} >= word_count_q) begin
              inst_out_d = NOP;
              oor_d      = 1'b1;
            end else begin
              inst_out_d = rd_word_c[W-1:0];
`ifdef INSTMEM_PARITY_EN
              perr_d     = ^rd_word_c;
`endif
            end
          end
        end
        default: ;
      endcase
    end

`ifdef INSTMEM_PARITY_EN
    // Parity bit sits above the data so the stored entry has even weight.
    mem_wdata_c = {^asm_d, asm_d};
`else
    mem_wdata_c = asm_d;
`endif

    loading_d    = (state_d == ST_LOAD);
    load_ready_d = (state_d == ST_LOAD) && (word_count_d < (A+1)'(DEPTH));
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      chunk_cnt_q  <= '0;
      asm_q        <= '0;
      word_count_q <= '0;
      load_err_q   <= 1'b0;
      load_ready_q <= 1'b0;
      loading_q    <= 1'b0;
      inst_out_q   <= '0;
      inst_valid_q <= 1'b0;
      oor_q        <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      chunk_cnt_q  <= chunk_cnt_d;
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
      load_err_q   <= load_err_d;
      load_ready_q <= load_ready_d;
      loading_q    <= loading_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
      oor_q        <= oor_d;
      perr_q       <= perr_d;
    end
  end

  assign LoadReady  = load_ready_q;
  assign Loading    = loading_q;
  assign LoadErr    = load_err_q;
  assign WordCount  = word_count_q;
  assign InstOut    = inst_out_q;
  assign InstValid  = inst_valid_q;
  assign OutOfRange = oor_q;
  assign ParityErr  = perr_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed bench for inst_mem_loadable: a default-size instance for load,
// fetch, error and reset behaviour, plus an A=2 instance for the full-memory
// auto-RUN case. Fetch responses go through an expected-response queue.

module tb_inst_mem_loadable;

  localparam int unsigned A  = 10;
  localparam int unsigned W  = 9;
  localparam int unsigned LW = 3;
  localparam int unsigned CH = W / LW;
  localparam int unsigned A2 = 2;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          LoadStart, LoadEnd, LoadValid;
  logic [LW-1:0] LoadData;
  logic          LoadReady, Loading, LoadErr;
  logic [A:0]    WordCount;
  logic          FetchReq;
  logic [A-1:0]  InstAddress;
  logic [W-1:0]  InstOut;
  logic          InstValid, OutOfRange, ParityErr;

  logic          LoadStart2, LoadEnd2, LoadValid2;
  logic [LW-1:0] LoadData2;
  logic          LoadReady2, Loading2, LoadErr2;
  logic [A2:0]   WordCount2;
  logic          FetchReq2;
  logic [A2-1:0] InstAddress2;
  logic [W-1:0]  InstOut2;
  logic          InstValid2, OutOfRange2, ParityErr2;

  always #5 Clk = ~Clk;

  inst_mem_loadable #(.A(A), .W(W), .LW(LW), .NOP('0)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .LoadStart(LoadStart), .LoadEnd(LoadEnd), .LoadValid(LoadValid), .LoadData(LoadData),
    .LoadReady(LoadReady), .Loading(Loading), .LoadErr(LoadErr), .WordCount(WordCount),
    .FetchReq(FetchReq), .InstAddress(InstAddress), .InstOut(InstOut),
    .InstValid(InstValid), .OutOfRange(OutOfRange), .ParityErr(ParityErr)
  );

  inst_mem_loadable #(.A(A2), .W(W), .LW(LW), .NOP('0)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n),
    .LoadStart(LoadStart2), .LoadEnd(LoadEnd2), .LoadValid(LoadValid2), .LoadData(LoadData2),
    .LoadReady(LoadReady2), .Loading(Loading2), .LoadErr(LoadErr2), .WordCount(WordCount2),
    .FetchReq(FetchReq2), .InstAddress(InstAddress2), .InstOut(InstOut2),
    .InstValid(InstValid2), .OutOfRange(OutOfRange2), .ParityErr(ParityErr2)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] inst;
    logic         oor;
    logic         perr;
  } resp_t;

  resp_t        sb[$];
  int           checks = 0;
  int           errors = 0;

  // Reference model of the loaded program.
  logic [W-1:0] model_mem [int];
  int           mdl_wc  = 0;
  int           mdl_cnt = 0;
  logic [W-1:0] mdl_asm = '0;
  logic [W-1:0] last_inst = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: queue the response expected for this edge, then compare it.
  task automatic cyc(input logic v, input logic [W-1:0] inst, input logic oor, input logic perr);
    resp_t e;
    resp_t r;
    e.v = v; e.inst = inst; e.oor = oor; e.perr = perr;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    r = sb.pop_front();
    chk("inst_valid", InstValid, r.v);
    if (r.v) begin
      chk("inst_out", InstOut, r.inst);
      chk("out_of_range", OutOfRange, r.oor);
      chk("parity_err", ParityErr, r.perr);
      last_inst = r.inst;
    end
  endtask

  task automatic idle();
    FetchReq = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic start_load();
    LoadStart = 1'b1;
    idle();
    LoadStart = 1'b0;
    mdl_wc = 0; mdl_cnt = 0;
  endtask

  task automatic chunk(input logic [LW-1:0] c, input logic with_end);
    LoadValid = 1'b1; LoadData = c; LoadEnd = with_end;
    mdl_asm = {mdl_asm[W-LW-1:0], c};
    mdl_cnt++;
    if (mdl_cnt == CH) begin
      model_mem[mdl_wc] = mdl_asm;
      mdl_wc++;
      mdl_cnt = 0;
    end
    if (with_end) mdl_cnt = 0;
    idle();
    LoadValid = 1'b0; LoadEnd = 1'b0;
  endtask

  task automatic end_load();
    LoadEnd = 1'b1;
    idle();
    LoadEnd = 1'b0;
    mdl_cnt = 0;
  endtask

  task automatic fetch_exp(input logic [A-1:0] addr, input logic [W-1:0] inst, input logic oor);
    FetchReq = 1'b1; InstAddress = addr;
    cyc(1'b1, inst, oor, 1'b0);
    FetchReq = 1'b0;
  endtask

  task automatic fetch_mdl(input logic [A-1:0] addr);
    if (int'(addr) >= mdl_wc) fetch_exp(addr, '0, 1'b1);
    else                      fetch_exp(addr, model_mem[int'(addr)], 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_inst_out"},   InstOut,    '0);
    chk({tag, "_inst_valid"}, InstValid,  1'b0);
    chk({tag, "_oor"},        OutOfRange, 1'b0);
    chk({tag, "_perr"},       ParityErr,  1'b0);
    chk({tag, "_ready"},      LoadReady,  1'b0);
    chk({tag, "_loading"},    Loading,    1'b0);
    chk({tag, "_load_err"},   LoadErr,    1'b0);
    chk({tag, "_word_count"}, WordCount,  '0);
  endtask

  initial begin
    logic [W-1:0] wd;
    Reset_n = 1'b1;
    LoadStart = 0; LoadEnd = 0; LoadValid = 0; LoadData = '0;
    FetchReq = 0; InstAddress = '0;
    LoadStart2 = 0; LoadEnd2 = 0; LoadValid2 = 0; LoadData2 = '0;
    FetchReq2 = 0; InstAddress2 = '0;
    #2 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk_all_zero("reset");
    chk("reset_loading2", Loading2, 1'b0);
    chk("reset_wc2", WordCount2, '0);
    Reset_n = 1'b1;

    // IDLE ignores fetches.
    FetchReq = 1'b1; InstAddress = '0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    FetchReq = 1'b0;

    // Two-word load, then back-to-back fetches and an out-of-range fetch.
    start_load();
    chk("load_loading", Loading, 1'b1);
    chk("load_ready", LoadReady, 1'b1);
    chunk(3'b101, 1'b0); chunk(3'b010, 1'b0); chunk(3'b111, 1'b0);
    chunk(3'b000, 1'b0); chunk(3'b000, 1'b0); chunk(3'b001, 1'b0);
    end_load();
    chk("t1_word_count", WordCount, 11'd2);
    chk("t1_load_err", LoadErr, 1'b0);
    chk("t1_loading", Loading, 1'b0);
    fetch_exp(10'd0, 9'b101010111, 1'b0);
    fetch_exp(10'd1, 9'b000000001, 1'b0);
    fetch_exp(10'd5, 9'd0, 1'b1);
    idle();
    chk("inst_hold", InstOut, last_inst);

    // LoadStart beats a same-cycle fetch in RUN.
    FetchReq = 1'b1; InstAddress = '0; LoadStart = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    FetchReq = 1'b0; LoadStart = 1'b0;
    mdl_wc = 0; mdl_cnt = 0;
    chk("restart_loading", Loading, 1'b1);
    chk("restart_wc", WordCount, '0);

    // One full word plus a partial word leaves LoadErr set.
    chunk(3'b111, 1'b0); chunk(3'b000, 1'b0); chunk(3'b101, 1'b0);
    chunk(3'b011, 1'b0); chunk(3'b110, 1'b0);
    end_load();
    chk("partial_wc", WordCount, 11'd1);
    chk("partial_err", LoadErr, 1'b1);
    fetch_mdl(10'd0);
    fetch_mdl(10'd1);

    // Restart clears error and count; chunk with LoadEnd completes the word.
    start_load();
    chk("clr_err", LoadErr, 1'b0);
    chk("clr_wc", WordCount, '0);
    chunk(3'b010, 1'b0); chunk(3'b100, 1'b0); chunk(3'b011, 1'b1);
    chk("end_chunk_wc", WordCount, 11'd1);
    chk("end_chunk_err", LoadErr, 1'b0);
    fetch_mdl(10'd0);

    // Reset in the middle of a word.
    start_load();
    chunk(3'b110, 1'b0);
    #3 Reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    mdl_wc = 0; mdl_cnt = 0;
    FetchReq = 1'b1; InstAddress = '0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    FetchReq = 1'b0;
    start_load();
    chunk(3'b001, 1'b0); chunk(3'b110, 1'b0); chunk(3'b010, 1'b0);
    end_load();
    fetch_mdl(10'd0);
    fetch_mdl(10'd1);

    // A=2 instance: fill all four words and check auto-RUN.
    LoadStart2 = 1'b1;
    idle();
    LoadStart2 = 1'b0;
    wd = '0;
    for (int k = 0; k < 4; k++) begin
      wd = W'(9'h0A5 + 9'd61 * k);
      for (int j = 0; j < int'(CH); j++) begin
        LoadValid2 = 1'b1;
        LoadData2 = wd[W-1-LW*j -: LW];
        idle();
        if (k == 2 && j == int'(CH) - 1) begin
          chk("a2_ready_3words", LoadReady2, 1'b1);
          chk("a2_wc_3words", WordCount2, 3'd3);
        end
      end
    end
    chk("a2_loading", Loading2, 1'b0);
    chk("a2_ready", LoadReady2, 1'b0);
    chk("a2_wc", WordCount2, 3'd4);
    LoadData2 = 3'b111;
    idle();
    LoadValid2 = 1'b0;
    chk("a2_extra_wc", WordCount2, 3'd4);
    FetchReq2 = 1'b1; InstAddress2 = 2'd3;
    idle();
    FetchReq2 = 1'b0;
    chk("a2_fetch_valid", InstValid2, 1'b1);
    chk("a2_fetch_inst", InstOut2, wd);
    chk("a2_fetch_oor", OutOfRange2, 1'b0);

`ifdef INSTMEM_PARITY_EN
    // Corrupt one stored data bit and expect a parity flag on fetch.
    dut.mem[0][0] = ~dut.mem[0][0];
    FetchReq = 1'b1; InstAddress = '0;
    cyc(1'b1, model_mem[0] ^ 9'd1, 1'b0, 1'b1);
    FetchReq = 1'b0;
`endif

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
- Parametrised successor to the fixed instruction ROM.
- Synchronous-read instruction memory with a chunk-serial programming port, so programs load at run time instead of from a file at elaboration.
- Sits between the fetch stage and the test harness or boot source.
- Fetch is a registered one-cycle-latency request/response port, gated by a load/run state machine.

Parameters:
- A, 10, address width; depth is 2**A words.
- W, 9, instruction width in bits.
- LW, 3, load chunk width in bits; W must be a multiple of LW (elaboration error otherwise); CH = W/LW chunks per word.
- NOP, 0, W-bit value returned for out-of-range fetches.

Ports:
- Clk, in, 1, clock; all state updates on posedge.
- Reset_n, in, 1, asynchronous active-low reset.
- LoadStart, in, 1, single-cycle pulse that begins or restarts a program load.
- LoadEnd, in, 1, single-cycle pulse that ends the load.
- LoadValid, in, 1, a chunk is present on LoadData.
- LoadData, in, LW, chunk data, most significant chunk first.
- LoadReady, out, 1, block can accept a chunk this cycle.
- Loading, out, 1, high while state is LOAD.
- LoadErr, out, 1, sticky flag: load ended with a partial word; cleared by LoadStart.
- WordCount, out, A+1, number of complete words written by the last load.
- FetchReq, in, 1, fetch request.
- InstAddress, in, A, fetch address, sampled when FetchReq=1.
- InstOut, out, W, fetched instruction.
- InstValid, out, 1, InstOut is valid this cycle.
- OutOfRange, out, 1, the fetch address was >= WordCount; qualified by InstValid.
- ParityErr, out, 1, parity mismatch on the fetched word; qualified by InstValid.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0: InstOut, InstValid, OutOfRange, ParityErr, LoadReady, Loading, LoadErr, WordCount.
  - Write pointer and chunk counter cleared.
  - Memory array is not cleared.
- States: IDLE, LOAD, RUN.
- IDLE: LoadStart goes to LOAD. FetchReq is ignored. LoadReady=0.
- LOAD:
  - Loading=1.
  - LoadReady=1 unless the memory is full.
  - Each cycle with LoadValid&&LoadReady shifts LoadData into the assembly register, MSB-first.
  - On the CH-th chunk, the assembled word is written to mem[WrPtr] on that edge; WrPtr and WordCount each increment by 1.
  - A write to address 2**A-1 moves the state to RUN automatically (WordCount=2**A); LoadReady drops the same edge.
  - LoadEnd moves the state to RUN. If the chunk counter is nonzero, the partial word is discarded and LoadErr is set.
  - A chunk accepted in the same cycle as LoadEnd is counted before the partial check.
- RUN:
  - FetchReq=1 at edge N gives InstValid=1 at edge N+1, with InstOut = mem[InstAddress] and OutOfRange=0.
  - If InstAddress >= WordCount: InstOut=NOP and OutOfRange=1.
  - FetchReq=0 gives InstValid=0. InstOut holds its last value.
  - Back-to-back fetches sustain one per cycle.
- LoadStart priority, in any state:
  - Goes to LOAD; clears WrPtr, chunk counter, WordCount and LoadErr; discards any partial word.
  - Beats a simultaneous LoadEnd, LoadValid or FetchReq.
  - A same-cycle FetchReq in RUN produces no response (InstValid=0 next cycle).
- LoadEnd outside LOAD is ignored.
- InstValid is forced 0 in IDLE and LOAD.
- Reset mid-load aborts the load: IDLE, WordCount=0. Words already written stay in the array but are reported out of range.

Optional Feature:
- Macro: INSTMEM_PARITY_EN.
- Defined:
  - Array entries are W+1 bits; even parity over the word is computed and stored on write.
  - Each fetch recomputes parity. On mismatch, ParityErr=1 alongside InstValid; InstOut still returns the stored W bits.
  - NOP/out-of-range responses give ParityErr=0.
- Undefined: array is W bits and ParityErr is tied to 0.

Test Plan:
- Reset, then LoadStart; chunks 3'b101, 3'b010, 3'b111, 3'b000, 3'b000, 3'b001; LoadEnd -> WordCount=2, LoadErr=0; fetch addr 0 then 1 on consecutive cycles -> InstOut 9'b101010111 then 9'b000000001, InstValid on the cycle after each request.
- After the load above, fetch addr 5 -> InstOut=NOP (0), OutOfRange=1, InstValid=1.
- Load 1 full word plus 2 chunks, then LoadEnd -> WordCount=1, LoadErr=1; a following LoadStart clears LoadErr and WordCount.
- A=2: stream 12 chunks -> auto-RUN after the 4th word, LoadReady=0, WordCount=4; a 13th LoadValid is not accepted.
- Assert Reset_n=0 mid-word during LOAD -> all outputs 0 immediately; state IDLE; FetchReq is ignored until a new load completes.
- With INSTMEM_PARITY_EN: load a word, force-flip one stored data bit, fetch it -> ParityErr=1 with InstValid=1. Without the macro -> ParityErr=0 throughout.
